// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional two-entry skid, flush and bubble-masked control.
// Latency 1 cycle; SKID=1 registers in_ready (drops one cycle after stall, skid absorbs), SKID=0 in_ready = !valid | out_ready.
module pipe_stage_reg #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 101,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  generate
    if (SKID) begin : g_skid
      typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
      } state_t;

      state_t            state, state_nxt;
      logic              rdy_q;
      logic              accept, emit;
      logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
      logic [DATA_W-1:0] main_data, skid_data;

      assign accept = in_valid & rdy_q;
      assign emit   = (state != EMPTY) & out_ready;

      always_comb begin
        state_nxt = state;
        if (flush) begin
          state_nxt = EMPTY;
        end else begin
          case (state)
            EMPTY: if (accept) state_nxt = ONE;
            ONE: begin
              if (accept && !emit)      state_nxt = TWO;
              else if (!accept && emit) state_nxt = EMPTY;
            end
            TWO:     if (emit) state_nxt = ONE;
            default: state_nxt = EMPTY;
          endcase
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state     <= EMPTY;
          rdy_q     <= 1'b0;
          main_ctrl <= '0;
          main_data <= '0;
          skid_ctrl <= '0;
          skid_data <= '0;
        end else begin
          state <= state_nxt;
          // Registered ready: only a full skid blocks upstream next cycle.
          rdy_q <= (state_nxt != TWO);
          if (flush) begin
            main_ctrl <= '0;
            skid_ctrl <= '0;
          end else begin
            case (state)
              EMPTY: begin
                if (accept) begin
                  main_ctrl <= in_ctrl;
                  main_data <= in_data;
                end
              end
              ONE: begin
                if (accept && emit) begin
                  main_ctrl <= in_ctrl;
                  main_data <= in_data;
                end else if (accept) begin
                  skid_ctrl <= in_ctrl;
                  skid_data <= in_data;
                end
              end
              TWO: begin
                if (emit) begin
                  main_ctrl <= skid_ctrl;
                  main_data <= skid_data;
                end
              end
              default: ;
            endcase
          end
        end
      end

      assign in_ready  = rdy_q;
      assign out_valid = (state != EMPTY);
      assign out_ctrl  = (state != EMPTY) ? main_ctrl : '0;
      assign out_data  = main_data;
      assign occupancy = (state == TWO) ? 2'd2 : (state == ONE) ? 2'd1 : 2'd0;
    end else begin : g_single
      logic              main_valid;
      logic              accept, emit;
      logic [CTRL_W-1:0] main_ctrl;
      logic [DATA_W-1:0] main_data;

      assign in_ready = !main_valid | out_ready;
      assign accept   = in_valid & in_ready;
      assign emit     = main_valid & out_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          main_valid <= 1'b0;
          main_ctrl  <= '0;
          main_data  <= '0;
        end else if (flush) begin
          main_valid <= 1'b0;
          main_ctrl  <= '0;
        end else if (accept) begin
          main_valid <= 1'b1;
          main_ctrl  <= in_ctrl;
          main_data  <= in_data;
        end else if (emit) begin
          main_valid <= 1'b0;
        end
      end

      assign out_valid = main_valid;
      assign out_ctrl  = main_valid ? main_ctrl : '0;
      assign out_data  = main_data;
      assign occupancy = {1'b0, main_valid};
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid instance via vector table, single-register instance via hand sequence.
module tb_pipe_stage_reg;

  localparam int CW = 3;
  localparam int DW = 101;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          s1_iv, s1_ir, s1_ov, s1_ordy, s1_fl;
  logic [CW-1:0] s1_ic, s1_oc;
  logic [DW-1:0] s1_id, s1_od;
  logic [1:0]    s1_occ;

  logic          s0_iv, s0_ir, s0_ov, s0_ordy, s0_fl;
  logic [CW-1:0] s0_ic, s0_oc;
  logic [DW-1:0] s0_id, s0_od;
  logic [1:0]    s0_occ;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s1_iv), .in_ready(s1_ir), .in_ctrl(s1_ic), .in_data(s1_id),
    .out_valid(s1_ov), .out_ready(s1_ordy), .out_ctrl(s1_oc), .out_data(s1_od),
    .flush(s1_fl), .occupancy(s1_occ)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) u_s0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s0_iv), .in_ready(s0_ir), .in_ctrl(s0_ic), .in_data(s0_id),
    .out_valid(s0_ov), .out_ready(s0_ordy), .out_ctrl(s0_oc), .out_data(s0_od),
    .flush(s0_fl), .occupancy(s0_occ)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Every completed downstream handshake, in order.
  logic [7:0] em1[$];
  logic [7:0] em0[$];
  always @(posedge clk) begin
    if (s1_ov && s1_ordy) em1.push_back(s1_od[7:0]);
    if (s0_ov && s0_ordy) em0.push_back(s0_od[7:0]);
  end

  typedef struct packed {
    logic       iv;
    logic [2:0] ic;
    logic [7:0] id;
    logic       ordy;
    logic       fl;
    logic       ov;
    logic [2:0] oc;
    logic [7:0] od;
    logic [1:0] occ;
    logic       ir;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [2:0] ic, logic [7:0] id, logic ordy, logic fl,
                              logic ov, logic [2:0] oc, logic [7:0] od, logic [1:0] occ, logic ir);
    vec_t v;
    v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy; v.fl = fl;
    v.ov = ov; v.oc = oc; v.od = od; v.occ = occ; v.ir = ir;
    return v;
  endfunction

  vec_t tbl[$];
  logic [7:0] exp_em1 [16] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8,
                               8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd20, 8'd30};
  logic [7:0] exp_em0 [4]  = '{8'd1, 8'd2, 8'd3, 8'd4};

  initial begin
    // pass-through 1..8
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(1, 3'(i), 8'(i), 1, 0, 1, 3'(i), 8'(i), 2'd1, 1));
    tbl.push_back(mk(0, 3'd0, 8'd0, 1, 0, 0, 3'd0, 8'd0, 2'd0, 1));
    // backpressure: stall 3 cycles after entry 2 shown
    tbl.push_back(mk(1, 3'd1, 8'd1, 1, 0, 1, 3'd1, 8'd1, 2'd1, 1));
    tbl.push_back(mk(1, 3'd2, 8'd2, 1, 0, 1, 3'd2, 8'd2, 2'd1, 1));
    tbl.push_back(mk(1, 3'd3, 8'd3, 0, 0, 1, 3'd2, 8'd2, 2'd2, 0));
    tbl.push_back(mk(1, 3'd4, 8'd4, 0, 0, 1, 3'd2, 8'd2, 2'd2, 0));
    tbl.push_back(mk(1, 3'd4, 8'd4, 0, 0, 1, 3'd2, 8'd2, 2'd2, 0));
    tbl.push_back(mk(1, 3'd4, 8'd4, 1, 0, 1, 3'd3, 8'd3, 2'd1, 1));
    tbl.push_back(mk(1, 3'd4, 8'd4, 1, 0, 1, 3'd4, 8'd4, 2'd1, 1));
    tbl.push_back(mk(1, 3'd5, 8'd5, 1, 0, 1, 3'd5, 8'd5, 2'd1, 1));
    tbl.push_back(mk(1, 3'd6, 8'd6, 1, 0, 1, 3'd6, 8'd6, 2'd1, 1));
    tbl.push_back(mk(0, 3'd0, 8'd0, 1, 0, 0, 3'd0, 8'd0, 2'd0, 1));
    // flush while holding two entries, with an offered entry 12
    tbl.push_back(mk(1, 3'd5, 8'd10, 0, 0, 1, 3'd5, 8'd10, 2'd1, 1));
    tbl.push_back(mk(1, 3'd6, 8'd11, 0, 0, 1, 3'd5, 8'd10, 2'd2, 0));
    tbl.push_back(mk(1, 3'd7, 8'd12, 0, 1, 0, 3'd0, 8'd0, 2'd0, 1));
    tbl.push_back(mk(0, 3'd0, 8'd0, 1, 0, 0, 3'd0, 8'd0, 2'd0, 1));
    // flush coinciding with an emit
    tbl.push_back(mk(1, 3'd3, 8'd20, 0, 0, 1, 3'd3, 8'd20, 2'd1, 1));
    tbl.push_back(mk(0, 3'd0, 8'd0, 1, 1, 0, 3'd0, 8'd0, 2'd0, 1));
    // bubbles carrying all-ones control
    tbl.push_back(mk(0, 3'd7, 8'h55, 1, 0, 0, 3'd0, 8'd0, 2'd0, 1));
    tbl.push_back(mk(0, 3'd7, 8'h55, 0, 0, 0, 3'd0, 8'd0, 2'd0, 1));
    tbl.push_back(mk(1, 3'd7, 8'd30, 0, 0, 1, 3'd7, 8'd30, 2'd1, 1));
    tbl.push_back(mk(0, 3'd7, 8'h55, 1, 0, 0, 3'd0, 8'd0, 2'd0, 1));

    rst_n = 1'b0;
    s1_iv = 0; s1_ic = '0; s1_id = '0; s1_ordy = 0; s1_fl = 0;
    s0_iv = 0; s0_ic = '0; s0_id = '0; s0_ordy = 0; s0_fl = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst s1 out_valid", s1_ov, 0);
    chk("rst s1 out_ctrl", s1_oc, 0);
    chk("rst s1 out_data", s1_od, 0);
    chk("rst s1 in_ready", s1_ir, 0);
    chk("rst s1 occupancy", s1_occ, 0);
    chk("rst s0 in_ready", s0_ir, 1);
    chk("rst s0 out_valid", s0_ov, 0);
    chk("rst s0 occupancy", s0_occ, 0);

    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("s1 in_ready after release", s1_ir, 1);

    for (int r = 0; r < tbl.size(); r++) begin
      s1_iv = tbl[r].iv; s1_ic = tbl[r].ic; s1_id = DW'(tbl[r].id);
      s1_ordy = tbl[r].ordy; s1_fl = tbl[r].fl;
      @(posedge clk);
      #1;
      chk($sformatf("s1 row %0d out_valid", r), s1_ov, tbl[r].ov);
      chk($sformatf("s1 row %0d out_ctrl", r), s1_oc, tbl[r].oc);
      if (tbl[r].ov) chk($sformatf("s1 row %0d out_data", r), s1_od, 128'(tbl[r].od));
      chk($sformatf("s1 row %0d occupancy", r), s1_occ, tbl[r].occ);
      chk($sformatf("s1 row %0d in_ready", r), s1_ir, tbl[r].ir);
    end
    s1_iv = 0; s1_ordy = 0; s1_fl = 0;

    // single-register variant, out_ready toggling
    begin
      int k;
      logic mv, acc, em, exp_ir;
      logic [7:0] md;
      k = 1; mv = 0; md = '0;
      for (int c = 0; c < 10; c++) begin
        s0_ordy = (c % 2 == 0);
        s0_iv = (k <= 4);
        s0_id = DW'(k);
        s0_ic = 3'(k);
        #1;
        exp_ir = !mv | s0_ordy;
        chk($sformatf("s0 c%0d in_ready", c), s0_ir, exp_ir);
        chk($sformatf("s0 c%0d in_ready rel", c), s0_ir, !s0_ov | s0_ordy);
        chk($sformatf("s0 c%0d out_valid", c), s0_ov, mv);
        chk($sformatf("s0 c%0d out_ctrl", c), s0_oc, mv ? md[2:0] : 3'd0);
        if (mv) chk($sformatf("s0 c%0d out_data", c), s0_od, 128'(md));
        chk($sformatf("s0 c%0d occupancy", c), s0_occ, {1'b0, mv});
        acc = s0_iv & exp_ir;
        em = mv & s0_ordy;
        if (acc) begin
          mv = 1; md = 8'(k); k++;
        end else if (em) begin
          mv = 0;
        end
        @(posedge clk);
        #1;
      end
      s0_iv = 0; s0_ordy = 0;
    end

    // asynchronous reset with an entry held
    s1_iv = 1; s1_ic = 3'd2; s1_id = DW'(8'h44); s1_ordy = 0;
    @(posedge clk);
    #1;
    s1_iv = 0;
    chk("s1 loaded before async rst", s1_ov, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", s1_ov, 0);
    chk("async rst out_ctrl", s1_oc, 0);
    chk("async rst out_data", s1_od, 0);
    chk("async rst occupancy", s1_occ, 0);
    chk("async rst in_ready", s1_ir, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("s1 in_ready after 2nd release", s1_ir, 1);

    chk("s1 emit count", em1.size(), 16);
    for (int i = 0; i < 16 && i < em1.size(); i++)
      chk($sformatf("s1 emit %0d", i), em1[i], exp_em1[i]);
    chk("s0 emit count", em0.size(), 4);
    for (int i = 0; i < 4 && i < em0.size(); i++)
      chk($sformatf("s0 emit %0d", i), em0[i], exp_em0[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, optional skid buffer, synchronous flush and control-field bubble masking. It is the successor of the fixed-field inter-stage registers: one instance replaces any of IF_ID, ID_EX, EX_MEM or MEM_WB, adding stall (backpressure), flush and bubble handling that plain registers lack. Fields are packed into a control bus, zeroed on bubbles, and a data bus that only needs to be correct when valid.

## Interface
- CTRL_W, 3: width of control field; zeroed whenever the stage holds no valid entry (e.g. {RegWrite, ResultSrc}).
- DATA_W, 101: width of data field (e.g. {AluResult, ReadData, Rd, PCPlus4} = 32+32+5+32).
- SKID, 1: 1 = two-entry skid buffer, fully registered handshake; 0 = single register, combinational in_ready.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage accepts entry this cycle.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream data field.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts entry this cycle.
- out_ctrl  out  CTRL_W  control field; all-zero when out_valid=0.
- out_data  out  DATA_W  data field; meaningful only when out_valid=1.
- flush  in  1  synchronous kill of all held entries.
- occupancy  out  2  number of held entries (0..2; max 1 when SKID=0).

## Operation
- accept = in_valid & in_ready; emit = out_valid & out_ready.
- SKID=1 states: EMPTY (occupancy 0), ONE (main full), TWO (main + skid full).
- EMPTY: accept -> ONE, main <= in.
- ONE: accept & emit -> ONE, main <= in; accept & !emit -> TWO, skid <= in; !accept & emit -> EMPTY; neither -> hold.
- TWO: in_ready=0, no accept; emit -> ONE, main <= skid; else hold.
- in_ready (SKID=1) is a register: next value = (next state != TWO) & !reset; 0 during reset, 1 from first clk edge after rst_n release.
- SKID=0: single main register; in_ready = !main_valid | out_ready (combinational). accept loads main; emit without accept empties it.
- flush has priority over all transfers: next state EMPTY, both valid bits and stored ctrl cleared, data registers not cleared. An emit in the flush cycle still completes (downstream consumes it). An accept in the flush cycle is discarded. SKID=1: in_ready is 1 in the cycle after flush.
- out_ctrl = main_valid ? main_ctrl : 0; bubbles never carry RegWrite/MemWrite-type control.
- Entry order is strict FIFO; no entry duplicated or dropped except by flush.
- Reset (rst_n low, asynchronous): state EMPTY, out_valid=0, out_ctrl=0, out_data=0, skid contents 0, occupancy=0, in_ready=0 (SKID=1) / 1 (SKID=0, as !main_valid).

## Timing
- Latency: accepted entry appears on out_* on the next clk edge (1 cycle) when stage was EMPTY or emitting.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- SKID=1: no combinational path between in_* and out_*, nor from out_ready to in_ready; in_ready drops one cycle after the stall begins, skid absorbs the in-flight entry.
- SKID=0: combinational path out_ready -> in_ready only.
- Mid-operation reset: outputs reach reset values asynchronously; held entries lost.
- rst_n release is synchronised externally; block requires deassertion clean w.r.t. clk.

## Test plan
- Reset/pass-through (SKID=1): rst_n low -> out_valid=0, out_ctrl=0, in_ready=0; release, stream data 1..8, out_ready=1 -> out_data 1..8, one per cycle, each 1 cycle after acceptance, occupancy 1.
- Backpressure: stream 1..6, drop out_ready for 3 cycles after entry 2 shown -> occupancy 2, in_ready=0 one cycle later, no loss; on release out_data 2,3,4,5,6 in order.
- Flush at TWO: hold entries 10,11, assert flush with in_valid=1 data 12 and out_ready=0 -> next cycle out_valid=0, out_ctrl=0, occupancy 0, in_ready=1; 12 never appears.
- Flush with emit: out_valid=1 data 20, out_ready=1, flush=1 -> 20 consumed that cycle, stage EMPTY after.
- Bubble masking: in_valid=0 with in_ctrl=3'b111 -> out_ctrl stays 3'b000.
- SKID=0: stream 1..4 with out_ready toggling 1,0,1,0 -> in_ready equals !out_valid|out_ready each cycle, output 1..4 in order, occupancy never exceeds 1.
